cpu_out_buffer: RTL



---
 rtl/cpu_out_pkg.sv | 25 ++
 rtl/cpu_out_decfmt.sv | 99 +++++++++
 rtl/cpu_out_buffer.sv | 89 ++++++++
 3 files changed

// File: rtl/cpu_out_pkg.sv
// cpu_out_pkg: shared types and constants for the CPU output buffer and its
// optional decimal formatter (enabled by CPU_OUT_DECFMT_EN).
`default_nettype none

package cpu_out_pkg;

    typedef struct packed {
        logic       is_char;
        logic [7:0] data;
    } out_entry_t;

    typedef enum logic [2:0] {
        FMT_IDLE = 3'd0,
        FMT_H    = 3'd1,
        FMT_T    = 3'd2,
        FMT_U    = 3'd3,
        FMT_NL   = 3'd4
    } fmt_state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

endpackage

`default_nettype wire

// File: rtl/cpu_out_decfmt.sv
// cpu_out_decfmt: expands integer FIFO entries to ASCII decimal plus LF and
// passes characters through; pops the FIFO head only after its last byte.
`default_nettype none

module cpu_out_decfmt
    import cpu_out_pkg::*;
(
    input  logic       clk,
    input  logic       out_rst,
    input  logic       head_valid,
    input  out_entry_t head,
    output logic       head_pop,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_is_char
);

    fmt_state_t state, state_nxt;
    logic [1:0] hundreds;
    logic [3:0] tens;
    logic [7:0] rem100;
    logic [7:0] rem10;

    // Digit extraction by compare-subtract; head stays stable until popped.
    always_comb begin
        hundreds = 2'd0;
        rem100   = head.data;
        if (head.data >= 8'd200) begin
            hundreds = 2'd2;
            rem100   = head.data - 8'd200;
        end else if (head.data >= 8'd100) begin
            hundreds = 2'd1;
            rem100   = head.data - 8'd100;
        end
        tens  = 4'd0;
        rem10 = rem100;
        for (int i = 1; i <= 9; i++) begin
            if (rem100 >= 8'(10 * i)) begin
                tens  = 4'(i);
                rem10 = rem100 - 8'(10 * i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        head_pop  = 1'b0;
        out_valid = (state != FMT_IDLE);
        out_data  = 8'h00;
        case (state)
            FMT_IDLE: begin
                if (head_valid) begin
                    if (head.is_char)              state_nxt = FMT_U;
                    else if (head.data >= 8'd100)  state_nxt = FMT_H;
                    else if (head.data >= 8'd10)   state_nxt = FMT_T;
                    else                           state_nxt = FMT_U;
                end
            end
            FMT_H: begin
                out_data = ASCII_ZERO + {6'd0, hundreds};
                if (out_ready) state_nxt = FMT_T;
            end
            FMT_T: begin
                out_data = ASCII_ZERO + {4'd0, tens};
                if (out_ready) state_nxt = FMT_U;
            end
            FMT_U: begin
                out_data = head.is_char ? head.data : (ASCII_ZERO + rem10);
                if (out_ready) begin
                    if (head.is_char) begin
                        head_pop  = 1'b1;
                        state_nxt = FMT_IDLE;
                    end else begin
                        state_nxt = FMT_NL;
                    end
                end
            end
            FMT_NL: begin
                out_data = ASCII_LF;
                if (out_ready) begin
                    head_pop  = 1'b1;
                    state_nxt = FMT_IDLE;
                end
            end
            default: state_nxt = FMT_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge out_rst) begin
        if (out_rst) state <= FMT_IDLE;
        else         state <= state_nxt;
    end

    assign out_is_char = 1'b1;

endmodule

`default_nettype wire

// File: rtl/cpu_out_buffer.sv
// cpu_out_buffer: captures main_bus on Out/COut strobes into a tagged FIFO and
// drains it over valid/ready. Optional decimal formatter: CPU_OUT_DECFMT_EN.
`default_nettype none

module cpu_out_buffer
    import cpu_out_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          out_rst,
    input  logic [7:0]    main_bus,
    input  logic          int_ld_n,
    input  logic          char_ld_n,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          out_is_char,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          conflict
);

    localparam int AW = $clog2(DEPTH);

    out_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    out_entry_t    push_entry, head;
    logic          push_req, full, fifo_valid, fifo_ready, fifo_pop, do_push;

    // Integer strobe wins a conflict, so the tag is simply the int strobe level.
    assign push_req           = ~int_ld_n | ~char_ld_n;
    assign push_entry.is_char = int_ld_n;
    assign push_entry.data    = main_bus;

    assign full       = (count == CW'(DEPTH));
    assign fifo_valid = (count != '0);
    assign fifo_pop   = fifo_valid & fifo_ready;
    assign do_push    = push_req & (~full | fifo_pop);
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk or posedge out_rst) begin
        if (out_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            conflict <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, fifo_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req & full & ~fifo_pop) overflow <= 1'b1;
            if (~int_ld_n & ~char_ld_n)      conflict <= 1'b1;
        end
    end

`ifdef CPU_OUT_DECFMT_EN
    cpu_out_decfmt u_decfmt (
        .clk         (clk),
        .out_rst     (out_rst),
        .head_valid  (fifo_valid),
        .head        (head),
        .head_pop    (fifo_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_is_char (out_is_char)
    );
`else
    // Head is read from registered storage, so it only moves on a pop or first push.
    assign fifo_ready  = out_ready;
    assign out_valid   = fifo_valid;
    assign out_data    = head.data;
    assign out_is_char = head.is_char;
`endif

endmodule

`default_nettype wire
